// File: rtl/vend_pkg.sv
// Shared types and constants for the multi-product vending core.
// Holds the FSM state enum, coin values in 25-cent units and a one-hot decoder.
package vend_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DISPENSE,
        REFUND
    } vend_state_e;

    localparam int COIN1_UNITS    = 1;
    localparam int COIN2_UNITS    = 4;
    localparam int CENTS_PER_UNIT = 25;

    // Index of the single set bit plus a flag saying the vector really was one-hot.
    typedef struct packed {
        logic       valid;
        logic [3:0] idx;
    } onehot_t;

    // Decode a select vector of up to 16 slots; zero or multiple bits give valid=0.
    function automatic onehot_t onehot_idx(input logic [15:0] vec);
        onehot_t r;
        r.valid = (vec != 16'd0) && ((vec & (vec - 16'd1)) == 16'd0);
        r.idx   = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (vec[i]) begin
                r.idx = 4'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/vend_edge_det.sv
// Rising/falling edge detector: one previous-value register per input bit.
// Edges are combinational against the registered previous level.
module vend_edge_det #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sig,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    logic [WIDTH-1:0] prev_reg;

    // Remember last cycle's level of every input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_reg <= '0;
        end else begin
            prev_reg <= sig;
        end
    end

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        assign rise[gi] = sig[gi] & ~prev_reg[gi];
        assign fall[gi] = ~sig[gi] & prev_reg[gi];
    end

endmodule

// File: rtl/vending_machine_multi.sv
// N-product vending core: credit in 25-cent units, per-slot price and stock,
// timed change refund and an IDLE/DISPENSE/REFUND FSM.
// Optional macro VEND_AUDIT_EN adds saturating sales_count / sales_units outputs.
module vending_machine_multi
    import vend_pkg::*;
#(
    parameter int                          NUM_PRODUCTS = 4,
    parameter int                          CREDIT_W     = 8,
    parameter int                          STOCK_W      = 4,
    parameter int                          STOCK_INIT   = 10,
    parameter logic [NUM_PRODUCTS*CREDIT_W-1:0] PRICES  = 32'h08_06_03_01
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    coin1,
    input  logic                    coin2,
    input  logic [NUM_PRODUCTS-1:0] select,
    input  logic                    buy,
    input  logic                    refund,
    input  logic [NUM_PRODUCTS-1:0] load,
    output logic [CREDIT_W+4:0]     money,
    output logic [NUM_PRODUCTS-1:0] products,
    output logic [NUM_PRODUCTS-1:0] outofstock,
    output logic                    change_pulse,
    output logic                    coin_reject,
    output logic                    vend_fail
`ifdef VEND_AUDIT_EN
    ,
    output logic [15:0]             sales_count,
    output logic [23:0]             sales_units
`endif
);

    vend_state_e             state_reg, state_next;
    logic [CREDIT_W-1:0]     credit_reg, credit_next;
    logic [NUM_PRODUCTS-1:0] products_reg, products_next;
    logic [NUM_PRODUCTS-1:0] outofstock_reg;
    logic                    change_reg, change_next;
    logic                    reject_reg, reject_next;
    logic                    fail_reg, fail_next;
    logic [NUM_PRODUCTS-1:0] dec_en, load_en;
    logic [NUM_PRODUCTS-1:0] stock_zero;
    logic                    vend_ok;

    logic [3:0] rise_vec, fall_vec;
    logic       coin1_rise, coin2_rise, buy_rise, buy_fall, refund_rise;
    logic       unused_fall;

    vend_edge_det #(.WIDTH(4)) u_edge (
        .clk  (clk),
        .rst_n(rst_n),
        .sig  ({refund, buy, coin2, coin1}),
        .rise (rise_vec),
        .fall (fall_vec)
    );

    assign coin1_rise  = rise_vec[0];
    assign coin2_rise  = rise_vec[1];
    assign buy_rise    = rise_vec[2];
    assign refund_rise = rise_vec[3];
    assign buy_fall    = fall_vec[2];
    assign unused_fall = ^{fall_vec[3], fall_vec[1:0]};

    // Per-slot stock counters: reload wins over a decrement, never wrap below zero.
    for (genvar gi = 0; gi < NUM_PRODUCTS; gi++) begin : g_slot
        logic [STOCK_W-1:0] stock_reg;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                stock_reg <= STOCK_W'(STOCK_INIT);
            end else if (load_en[gi]) begin
                stock_reg <= '1;
            end else if (dec_en[gi] && (stock_reg != '0)) begin
                stock_reg <= stock_reg - 1'b1;
            end
        end

        assign stock_zero[gi] = (stock_reg == '0);
    end

    onehot_t             sel_oh;
    logic [CREDIT_W-1:0] price_sel;
    logic                stock_ok;

    assign sel_oh = onehot_idx(16'(select));

    // Look up price and stock availability for the selected slot.
    always_comb begin
        price_sel = '0;
        stock_ok  = 1'b0;
        for (int i = 0; i < NUM_PRODUCTS; i++) begin
            if (sel_oh.idx == 4'(i)) begin
                price_sel = PRICES[i*CREDIT_W +: CREDIT_W];
                stock_ok  = ~stock_zero[i];
            end
        end
    end

    // Coin arithmetic shared by IDLE and DISPENSE; an extra bit catches overflow.
    logic [CREDIT_W:0]   coin1_sum, coin2_sum;
    logic                coin_event, coin_rej;
    logic [CREDIT_W-1:0] coin_credit;

    always_comb begin
        coin1_sum   = {1'b0, credit_reg} + (CREDIT_W+1)'(COIN1_UNITS);
        coin2_sum   = {1'b0, credit_reg} + (CREDIT_W+1)'(COIN2_UNITS);
        coin_event  = coin1_rise | coin2_rise;
        coin_rej    = 1'b0;
        coin_credit = credit_reg;
        if (coin1_rise) begin
            if (coin1_sum[CREDIT_W]) begin
                coin_rej = 1'b1;
            end else begin
                coin_credit = coin1_sum[CREDIT_W-1:0];
            end
            // A simultaneous 100c edge cannot be credited in the same cycle.
            if (coin2_rise) begin
                coin_rej = 1'b1;
            end
        end else if (coin2_rise) begin
            if (coin2_sum[CREDIT_W]) begin
                coin_rej = 1'b1;
            end else begin
                coin_credit = coin2_sum[CREDIT_W-1:0];
            end
        end
    end

    // Next-state and output decode; only the highest-priority event acts in IDLE.
    always_comb begin
        state_next    = state_reg;
        credit_next   = credit_reg;
        products_next = products_reg;
        change_next   = 1'b0;
        reject_next   = 1'b0;
        fail_next     = 1'b0;
        dec_en        = '0;
        load_en       = '0;
        vend_ok       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (coin_event) begin
                    credit_next = coin_credit;
                    reject_next = coin_rej;
                end else if (buy_rise) begin
                    if (sel_oh.valid && (credit_reg >= price_sel) && stock_ok) begin
                        credit_next   = credit_reg - price_sel;
                        dec_en        = select;
                        products_next = select;
                        vend_ok       = 1'b1;
                        state_next    = DISPENSE;
                    end else begin
                        fail_next = 1'b1;
                    end
                end else if (refund_rise) begin
                    if (credit_reg != '0) begin
                        state_next = REFUND;
                    end
                end else begin
                    load_en = load;
                end
            end
            DISPENSE: begin
                if (coin_event) begin
                    credit_next = coin_credit;
                    reject_next = coin_rej;
                end
                if (buy_fall) begin
                    products_next = '0;
                    state_next    = IDLE;
                end
            end
            REFUND: begin
                reject_next = coin_event;
                if (credit_reg != '0) begin
                    change_next = 1'b1;
                    credit_next = credit_reg - 1'b1;
                end
                if (credit_reg <= CREDIT_W'(1)) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Core state, credit and registered pulse/flag outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            credit_reg     <= '0;
            products_reg   <= '0;
            outofstock_reg <= '0;
            change_reg     <= 1'b0;
            reject_reg     <= 1'b0;
            fail_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            credit_reg     <= credit_next;
            products_reg   <= products_next;
            outofstock_reg <= stock_zero;
            change_reg     <= change_next;
            reject_reg     <= reject_next;
            fail_reg       <= fail_next;
        end
    end

    assign money        = (CREDIT_W+5)'(credit_reg) * (CREDIT_W+5)'(CENTS_PER_UNIT);
    assign products     = products_reg;
    assign outofstock   = outofstock_reg;
    assign change_pulse = change_reg;
    assign coin_reject  = reject_reg;
    assign vend_fail    = fail_reg;

`ifdef VEND_AUDIT_EN
    logic [15:0] sales_count_reg;
    logic [23:0] sales_units_reg;
    logic [24:0] units_sum;

    assign units_sum = {1'b0, sales_units_reg} + 25'(price_sel);

    // Saturating audit counters, stepped once per successful vend.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sales_count_reg <= '0;
            sales_units_reg <= '0;
        end else if (vend_ok) begin
            if (sales_count_reg != '1) begin
                sales_count_reg <= sales_count_reg + 16'd1;
            end
            sales_units_reg <= units_sum[24] ? '1 : units_sum[23:0];
        end
    end

    assign sales_count = sales_count_reg;
    assign sales_units = sales_units_reg;
`else
    logic unused_audit;
    assign unused_audit = vend_ok;
`endif

endmodule
